inst_fetch_unit: RTL and testbench
==================================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch buffer entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_a  output  32  word address to the combinational instruction memory.
REQ-006 SHALL have port imem_inst  input  32  instruction word returned by memory in the same cycle as imem_a.
REQ-007 SHALL have port dec_valid  output  1  head entry valid toward the decoder.
REQ-008 SHALL have port dec_ready  input  1  decoder accepts the head entry this cycle.
REQ-009 SHALL have port dec_inst  output  32  head entry instruction.
REQ-010 SHALL have port dec_pc  output  32  head entry address.
REQ-011 SHALL have port redirect  input  1  branch/jump redirect request.
REQ-012 SHALL have port redirect_pc  input  32  redirect target.
REQ-013 SHALL have port halted  output  1  fetch stopped on the end-of-program marker.

Function
REQ-014 SHALL hold fetch_pc; imem_a SHALL equal fetch_pc every cycle.
REQ-015 A fetch SHALL occur in a cycle when halted=0, redirect=0, and the buffer is not full or a pop occurs that cycle.
REQ-016 On a fetch with imem_inst != 0, SHALL push {fetch_pc, imem_inst} and set fetch_pc = fetch_pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-017 On a fetch with imem_inst == 32'h0 (end marker), SHALL NOT push, SHALL hold fetch_pc and SHALL set halted=1 next cycle.
REQ-018 A pop SHALL occur when dec_valid and dec_ready are both 1; dec_valid SHALL be 1 exactly when the buffer is non-empty.
REQ-019 dec_inst/dec_pc SHALL be driven from the buffer head and SHALL be stable while dec_valid=1 and dec_ready=0.
REQ-020 Latency SHALL be 1 cycle: a word fetched in cycle N into an empty buffer appears on dec_* in cycle N+1.
REQ-021 Simultaneous push and pop SHALL keep the occupancy unchanged; push into a full buffer without a pop SHALL never occur.
REQ-022 Redirect SHALL win over push and pop in the same cycle: flush all entries (dec_valid=0 next cycle), set fetch_pc = {redirect_pc[31:2],2'b00}, clear halted.
REQ-023 After redirect, the first target instruction SHALL appear on dec_* no earlier than 2 cycles after redirect asserts.
REQ-024 While halted=1, no fetch SHALL occur; buffered entries SHALL still drain normally.
REQ-025 Occupancy counter SHALL be $clog2(DEPTH)+1 bits; read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-026 With rst=1 at a clock edge: fetch_pc=RESET_PC, buffer empty (dec_valid=0), halted=0, pointers/count=0.
REQ-027 Reset SHALL override redirect and any in-flight push/pop in the same cycle.
REQ-028 dec_inst and dec_pc SHALL read 0 while the buffer is empty.

Structure
REQ-029 The shared package SHALL hold the constants END_MARKER=32'h0 and INST_BYTES=4.
REQ-030 The buffer SHALL be one sub-module, fetch_fifo (DEPTH x 64-bit, push/pop/flush, full/empty/count outputs).

Verification
REQ-031 Reset, memory = 4 nonzero words then 0, dec_ready=1 -> dec_pc 0,4,8,12 in consecutive cycles from cycle 1; halted=1 at cycle 5; dec_valid=0 after.
REQ-032 dec_ready=0 for 10 cycles after reset -> exactly DEPTH=4 entries buffered, imem_a held at 16, dec_pc stays 0.
REQ-033 Redirect to 32'h0000_0042 while 3 entries are buffered and dec_ready=1 -> next cycle dec_valid=0, imem_a=32'h40; following cycle dec_pc=32'h40.
REQ-034 Halted at 0x30, then redirect to 0x8 -> halted=0 next cycle, fetch resumes at 0x8.
REQ-035 RESET_PC=32'hFFFF_FFF8, nonzero memory -> dec_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 rst asserted mid-stream with a full buffer and redirect=1 -> next cycle dec_valid=0, imem_a=RESET_PC, halted=0.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared fetch constants and the buffered {pc, inst} entry type
package inst_fetch_unit_pkg;
  localparam logic [31:0] END_MARKER = 32'h0000_0000;
  localparam logic [31:0] INST_BYTES = 32'd4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// fetch_fifo: DEPTH x 64-bit prefetch buffer (clk, rst, i_push/i_pop/i_flush, i_data -> o_data, o_full, o_empty, o_count)
module fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fetch_entry_t             i_data,
  output fetch_entry_t             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end
  assign o_data  = r_mem[r_rptr];
  assign o_empty = r_count == '0;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_count = r_count;
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: sequential prefetcher (imem_a/imem_inst fetch, dec_* handshake out, redirect flush, halted on end marker)
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_inst,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
);
  logic [31:0]            r_pc;
  logic                   r_halted;
  logic                   w_full, w_empty, w_pop, w_fetch, w_end, w_push;
  logic [$clog2(DEPTH):0] w_count;
  fetch_entry_t           w_head;
  assign w_end     = imem_inst == END_MARKER;
  assign w_pop     = dec_valid && dec_ready;
  assign w_fetch   = !r_halted && !redirect && (!w_full || w_pop);
  assign w_push    = w_fetch && !w_end;
  assign imem_a    = r_pc;
  assign halted    = r_halted;
  assign dec_valid = w_count != '0;
  assign dec_inst  = w_empty ? 32'h0 : w_head.inst;
  assign dec_pc    = w_empty ? 32'h0 : w_head.pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else if (redirect) begin
      r_pc     <= {redirect_pc[31:2], 2'b00};
      r_halted <= 1'b0;
    end else if (w_fetch) begin
      r_pc     <= w_end ? r_pc : r_pc + INST_BYTES;
      r_halted <= w_end;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_data  ('{pc: r_pc, inst: imem_inst}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;
  localparam logic [31:0] K = 32'h1357_0001;
  logic        clk = 1'b0;
  logic        rst, dec_ready, redirect;
  logic [31:0] redirect_pc, end_addr;
  logic [31:0] imem_a, imem_inst, dec_inst, dec_pc;
  logic        dec_valid, halted;
  logic [31:0] imem_a2, imem_inst2, dec_inst2, dec_pc2;
  logic        dec_valid2, halted2;
  int          n_cmp = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  assign imem_inst  = (imem_a == end_addr) ? 32'h0 : (imem_a ^ K);
  assign imem_inst2 = imem_a2 ^ K;
  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .imem_a(imem_a), .imem_inst(imem_inst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );
  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
    .clk(clk), .rst(rst), .imem_a(imem_a2), .imem_inst(imem_inst2),
    .dec_valid(dec_valid2), .dec_ready(1'b1), .dec_inst(dec_inst2), .dec_pc(dec_pc2),
    .redirect(1'b0), .redirect_pc(32'h0), .halted(halted2)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    redirect = 1'b0;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset;
    end_addr = 32'hFFFF_FFF0;
    dec_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    rst = 1'b1;
    tick();
    n_cmp++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", dec_valid); end
    n_cmp++; if (imem_a !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 00000000", imem_a); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %0b want 0", halted); end
    n_cmp++; if (dec_pc !== 32'h0 || dec_inst !== 32'h0) begin n_err++; $display("FAIL reset_empty_data got %h/%h want 0/0", dec_pc, dec_inst); end
    rst = 1'b0;
    redirect = 1'b0;
  endtask
  task automatic test_stream;
    logic [31:0] e;
    end_addr = 32'h0000_0010;
    dec_ready = 1'b1;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      tick();
      e = 32'((i - 1) * 4);
      n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== e) begin n_err++; $display("FAIL stream_pc[%0d] got v=%0b %h want v=1 %h", i, dec_valid, dec_pc, e); end
      n_cmp++; if (dec_inst !== (e ^ K)) begin n_err++; $display("FAIL stream_inst[%0d] got %h want %h", i, dec_inst, e ^ K); end
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL stream_early_halt[%0d] got %0b want 0", i, halted); end
    end
    tick();
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL stream_halted got %0b want 1", halted); end
    n_cmp++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL stream_drained got %0b want 0", dec_valid); end
    n_cmp++; if (imem_a !== 32'h10) begin n_err++; $display("FAIL stream_hold_pc got %h want 00000010", imem_a); end
    tick();
    n_cmp++; if (halted !== 1'b1 || dec_valid !== 1'b0 || imem_a !== 32'h10) begin n_err++; $display("FAIL stream_stay_halted got h=%0b v=%0b a=%h want h=1 v=0 a=00000010", halted, dec_valid, imem_a); end
  endtask
  task automatic test_backpressure;
    logic [31:0] e;
    end_addr = 32'hFFFF_FFF0;
    dec_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_inst !== K) begin n_err++; $display("FAIL stall_head[%0d] got v=%0b %h/%h want v=1 00000000/%h", i, dec_valid, dec_pc, dec_inst, K); end
    end
    n_cmp++; if (imem_a !== 32'h10) begin n_err++; $display("FAIL stall_full_pc got %h want 00000010", imem_a); end
    dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = 32'(i * 4);
      n_cmp++; if (dec_pc !== e || imem_a !== e + 32'h10) begin n_err++; $display("FAIL full_pushpop[%0d] got pc=%h a=%h want pc=%h a=%h", i, dec_pc, imem_a, e, e + 32'h10); end
      tick();
    end
  endtask
  task automatic test_redirect;
    end_addr = 32'hFFFF_FFF0;
    dec_ready = 1'b0;
    do_reset();
    repeat (3) tick();
    n_cmp++; if (imem_a !== 32'hC || dec_pc !== 32'h0) begin n_err++; $display("FAIL redir_setup got a=%h pc=%h want a=0000000c pc=00000000", imem_a, dec_pc); end
    dec_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0042;
    tick();
    redirect = 1'b0;
    n_cmp++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush got %0b want 0", dec_valid); end
    n_cmp++; if (imem_a !== 32'h40) begin n_err++; $display("FAIL redir_align got %h want 00000040", imem_a); end
    tick();
    n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 32'h40 || dec_inst !== (32'h40 ^ K)) begin n_err++; $display("FAIL redir_target got v=%0b %h/%h want v=1 00000040/%h", dec_valid, dec_pc, dec_inst, 32'h40 ^ K); end
  endtask
  task automatic test_halt_redirect;
    end_addr = 32'h0000_0030;
    dec_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 40 && !halted; i++) tick();
    n_cmp++; if (halted !== 1'b1 || imem_a !== 32'h30) begin n_err++; $display("FAIL halt_reach got h=%0b a=%h want h=1 a=00000030", halted, imem_a); end
    repeat (2) tick();
    n_cmp++; if (dec_valid !== 1'b0 || imem_a !== 32'h30) begin n_err++; $display("FAIL halt_idle got v=%0b a=%h want v=0 a=00000030", dec_valid, imem_a); end
    redirect = 1'b1;
    redirect_pc = 32'h0000_0008;
    tick();
    redirect = 1'b0;
    n_cmp++; if (halted !== 1'b0 || imem_a !== 32'h8) begin n_err++; $display("FAIL halt_resume got h=%0b a=%h want h=0 a=00000008", halted, imem_a); end
    tick();
    n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 32'h8 || imem_a !== 32'hC) begin n_err++; $display("FAIL halt_refetch got v=%0b pc=%h a=%h want v=1 pc=00000008 a=0000000c", dec_valid, dec_pc, imem_a); end
  endtask
  task automatic test_wrap;
    logic [31:0] exp_pc [3];
    exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    do_reset();
    n_cmp++; if (imem_a2 !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL wrap_reset_pc got %h want fffffff8", imem_a2); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (dec_valid2 !== 1'b1 || dec_pc2 !== exp_pc[i]) begin n_err++; $display("FAIL wrap_pc[%0d] got v=%0b %h want v=1 %h", i, dec_valid2, dec_pc2, exp_pc[i]); end
    end
  endtask
  task automatic test_reset_override;
    end_addr = 32'hFFFF_FFF0;
    dec_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    n_cmp++; if (imem_a !== 32'h10 || dec_valid !== 1'b1) begin n_err++; $display("FAIL ovr_setup got a=%h v=%0b want a=00000010 v=1", imem_a, dec_valid); end
    rst = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0080;
    dec_ready = 1'b1;
    tick();
    rst = 1'b0;
    redirect = 1'b0;
    n_cmp++; if (dec_valid !== 1'b0 || imem_a !== 32'h0 || halted !== 1'b0) begin n_err++; $display("FAIL ovr_reset got v=%0b a=%h h=%0b want v=0 a=00000000 h=0", dec_valid, imem_a, halted); end
    n_cmp++; if (dec_pc !== 32'h0 || dec_inst !== 32'h0) begin n_err++; $display("FAIL ovr_empty_data got %h/%h want 0/0", dec_pc, dec_inst); end
  endtask
  initial begin
    rst = 1'b1;
    dec_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    end_addr = 32'hFFFF_FFF0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt_redirect();
    test_wrap();
    test_reset_override();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
